// File: rtl/sysid_checker_pkg.sv
// sysid_checker_pkg: shared types and constants for the system-ID checker.
//   state_e  - checker FSM states
//   ADDR_ID  - slave word holding the system ID
//   ADDR_TS  - slave word holding the build timestamp
//   TO_W     - width of the per-transaction timeout counter
package sysid_checker_pkg;

  localparam int   TO_W    = 16;
  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    RD_ID_REQ,
    RD_ID_WAIT,
    RD_TS_REQ,
    RD_TS_WAIT,
    DONE
  } state_e;

endpackage

// File: rtl/sysid_checker_timer.sv
// sysid_checker_timer: per-transaction cycle counter.
//   clock, reset - clock, async active-high reset
//   clear        - reload the counter with zero (has priority over en)
//   en           - count this cycle
//   expired      - this enabled cycle is the TIMEOUT_CYCLES-th one
module sysid_checker_timer
  import sysid_checker_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)   cnt_d = '0;
    else if (en) cnt_d = cnt_q + TO_W'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // cnt_q holds the number of cycles already spent, so the limit is hit
  // during the cycle where cnt_q == TIMEOUT_CYCLES-1.
  assign expired = en && (cnt_q == LAST);

endmodule

// File: rtl/sysid_checker.sv
// sysid_checker: Avalon-MM read-only master that reads the system-ID slave
// (word 0 = ID, word 1 = build timestamp) after reset or on start, and
// compares both words against the expected build constants.
//   clock, reset         - clock, async active-high reset
//   start                - one-cycle check request (ignored while busy)
//   avm_*                - Avalon-MM read master port
//   busy                 - a read transaction is in progress
//   done                 - check finished, held until the next start
//   id_ok, ts_ok, timeout- result flags, valid while done
//   captured_id/ts       - last words read from the slave
module sysid_checker
  import sysid_checker_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'd291,
  parameter logic [31:0] EXPECTED_TS    = 32'd1493681950,
  parameter bit          CHECK_TS       = 1'b1,
  parameter bit          AUTO_START     = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic        avm_readdatavalid,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] captured_id,
  output logic [31:0] captured_ts
);

  state_e      state_q, state_d;
  logic        rd_q, rd_d;
  logic        addr_q, addr_d;
  logic        done_q, done_d;
  logic        id_ok_q, id_ok_d;
  logic        ts_ok_q, ts_ok_d;
  logic        tmo_q, tmo_d;
  logic        auto_q;
  logic [31:0] cid_q, cid_d;
  logic [31:0] cts_q, cts_d;
  logic        tmr_clr, tmr_exp, in_xfer;

  assign in_xfer = (state_q == RD_ID_REQ) || (state_q == RD_ID_WAIT) ||
                   (state_q == RD_TS_REQ) || (state_q == RD_TS_WAIT);

  sysid_checker_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (tmr_clr),
    .en      (in_xfer),
    .expired (tmr_exp)
  );

  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    addr_d  = addr_q;
    done_d  = done_q;
    id_ok_d = id_ok_q;
    ts_ok_d = ts_ok_q;
    tmo_d   = tmo_q;
    cid_d   = cid_q;
    cts_d   = cts_q;
    tmr_clr = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        // auto_q is only set on the first cycle after reset, and only in IDLE
        if (start || auto_q) begin
          state_d = RD_ID_REQ;
          rd_d    = 1'b1;
          addr_d  = ADDR_ID;
          tmr_clr = 1'b1;
          done_d  = 1'b0;
          id_ok_d = 1'b0;
          ts_ok_d = 1'b0;
          tmo_d   = 1'b0;
        end
      end
      RD_ID_REQ, RD_TS_REQ: begin
        if (tmr_exp) begin
          state_d = DONE;
          rd_d    = 1'b0;
          done_d  = 1'b1;
          tmo_d   = 1'b1;
        end else if (!avm_waitrequest) begin
          state_d = (state_q == RD_ID_REQ) ? RD_ID_WAIT : RD_TS_WAIT;
          rd_d    = 1'b0;
        end
      end
      RD_ID_WAIT: begin
        // returning data beats an expiry in the same cycle
        if (avm_readdatavalid) begin
          cid_d = avm_readdata;
          if (CHECK_TS) begin
            state_d = RD_TS_REQ;
            rd_d    = 1'b1;
            addr_d  = ADDR_TS;
            tmr_clr = 1'b1;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
            id_ok_d = (avm_readdata == EXPECTED_ID);
            ts_ok_d = 1'b1;
          end
        end else if (tmr_exp) begin
          state_d = DONE;
          done_d  = 1'b1;
          tmo_d   = 1'b1;
        end
      end
      RD_TS_WAIT: begin
        if (avm_readdatavalid) begin
          cts_d   = avm_readdata;
          state_d = DONE;
          done_d  = 1'b1;
          id_ok_d = (cid_q == EXPECTED_ID);
          ts_ok_d = (avm_readdata == EXPECTED_TS);
        end else if (tmr_exp) begin
          state_d = DONE;
          done_d  = 1'b1;
          tmo_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rd_q    <= 1'b0;
      addr_q  <= ADDR_ID;
      done_q  <= 1'b0;
      id_ok_q <= 1'b0;
      ts_ok_q <= 1'b0;
      tmo_q   <= 1'b0;
      auto_q  <= AUTO_START;
      cid_q   <= '0;
      cts_q   <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
      id_ok_q <= id_ok_d;
      ts_ok_q <= ts_ok_d;
      tmo_q   <= tmo_d;
      auto_q  <= 1'b0;
      cid_q   <= cid_d;
      cts_q   <= cts_d;
    end
  end

  assign avm_read    = rd_q;
  assign avm_address = addr_q;
  assign busy        = in_xfer;
  assign done        = done_q;
  assign id_ok       = id_ok_q;
  assign ts_ok       = ts_ok_q;
  assign timeout     = tmo_q;
  assign captured_id = cid_q;
  assign captured_ts = cts_q;

endmodule

// File: tb/tb_sysid_checker.sv
// Directed bench: three checker instances (default, TIMEOUT_CYCLES=10,
// CHECK_TS=0) each driven by a small Avalon slave model with programmable
// wait states, data values, muting and a one-cycle readdatavalid injector.
module tb_sysid_checker;

  localparam logic [31:0] EXP_ID = 32'd291;
  localparam logic [31:0] EXP_TS = 32'd1493681950;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst[3], start[3], rd[3], addr[3], wr[3], rdv[3];
  logic        busy[3], done[3], idok[3], tsok[3], tmo[3];
  logic [31:0] rdata[3], cid[3], cts[3];

  // slave model state and configuration
  logic        m_rdv[3], ts_seen[3], mute[3], inj[3];
  logic [31:0] m_data[3], slv_id[3], slv_ts[3], inj_data[3];
  int          wcnt[3], reads[3], wait_n[3];

  int checks = 0;
  int failures = 0;

  sysid_checker u0 (
    .clock(clock), .reset(rst[0]), .start(start[0]), .avm_address(addr[0]),
    .avm_read(rd[0]), .avm_waitrequest(wr[0]), .avm_readdatavalid(rdv[0]),
    .avm_readdata(rdata[0]), .busy(busy[0]), .done(done[0]), .id_ok(idok[0]),
    .ts_ok(tsok[0]), .timeout(tmo[0]), .captured_id(cid[0]), .captured_ts(cts[0]));

  sysid_checker #(.TIMEOUT_CYCLES(10), .AUTO_START(1'b0)) u1 (
    .clock(clock), .reset(rst[1]), .start(start[1]), .avm_address(addr[1]),
    .avm_read(rd[1]), .avm_waitrequest(wr[1]), .avm_readdatavalid(rdv[1]),
    .avm_readdata(rdata[1]), .busy(busy[1]), .done(done[1]), .id_ok(idok[1]),
    .ts_ok(tsok[1]), .timeout(tmo[1]), .captured_id(cid[1]), .captured_ts(cts[1]));

  sysid_checker #(.CHECK_TS(1'b0), .AUTO_START(1'b0)) u2 (
    .clock(clock), .reset(rst[2]), .start(start[2]), .avm_address(addr[2]),
    .avm_read(rd[2]), .avm_waitrequest(wr[2]), .avm_readdatavalid(rdv[2]),
    .avm_readdata(rdata[2]), .busy(busy[2]), .done(done[2]), .id_ok(idok[2]),
    .ts_ok(tsok[2]), .timeout(tmo[2]), .captured_id(cid[2]), .captured_ts(cts[2]));

  // Slave: waitrequest for wait_n cycles of each read, then data one cycle
  // after acceptance (suppressed when muted). Reset abandons the read.
  always @(posedge clock) begin
    for (int g = 0; g < 3; g++) begin
      if (rst[g]) begin
        m_rdv[g]   <= 1'b0;
        m_data[g]  <= '0;
        wcnt[g]    <= 0;
        reads[g]   <= 0;
        ts_seen[g] <= 1'b0;
      end else begin
        m_rdv[g] <= 1'b0;
        if (rd[g] && !wr[g]) begin
          m_rdv[g]  <= !mute[g];
          m_data[g] <= addr[g] ? slv_ts[g] : slv_id[g];
          wcnt[g]   <= 0;
          reads[g]  <= reads[g] + 1;
          if (addr[g]) ts_seen[g] <= 1'b1;
        end else if (rd[g] && wr[g]) begin
          wcnt[g] <= wcnt[g] + 1;
        end
      end
    end
  end

  always_comb begin
    for (int g = 0; g < 3; g++) begin
      wr[g]    = rd[g] && (wcnt[g] < wait_n[g]);
      rdv[g]   = m_rdv[g] | inj[g];
      rdata[g] = inj[g] ? inj_data[g] : m_data[g];
    end
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // start high for exactly one active edge; returns 1 time unit after it
  task automatic pulse_start(input int g);
    @(negedge clock);
    start[g] = 1'b1;
    @(posedge clock);
    #1;
    start[g] = 1'b0;
  endtask

  initial begin
    for (int g = 0; g < 3; g++) begin
      rst[g] = 1'b1; start[g] = 1'b0; slv_id[g] = EXP_ID; slv_ts[g] = EXP_TS;
      wait_n[g] = 0; mute[g] = 1'b0; inj[g] = 1'b0; inj_data[g] = '0;
    end
    mute[1] = 1'b1;

    // reset state
    tick(); tick();
    chk1("rst_done", done[0], 1'b0);
    chk1("rst_busy", busy[0], 1'b0);
    chk1("rst_read", rd[0], 1'b0);
    chk1("rst_idok", idok[0], 1'b0);
    chk1("rst_timeout", tmo[0], 1'b0);
    chk32("rst_cid", cid[0], 32'd0);

    // auto check after reset release: done on the 5th edge
    @(negedge clock);
    for (int g = 0; g < 3; g++) rst[g] = 1'b0;
    tick(); tick(); tick(); tick();
    chk1("auto_busy4", busy[0], 1'b1);
    chk1("auto_done4", done[0], 1'b0);
    tick();
    chk1("auto_done5", done[0], 1'b1);
    chk1("auto_idok", idok[0], 1'b1);
    chk1("auto_tsok", tsok[0], 1'b1);
    chk1("auto_timeout", tmo[0], 1'b0);
    chk32("auto_cid", cid[0], EXP_ID);
    chk32("auto_cts", cts[0], EXP_TS);
    chk1("idle_no_auto_u2", busy[2], 1'b0);

    // wrong ID, then matching ID again
    slv_id[0] = 32'd292;
    pulse_start(0);
    chk1("bad_clr_done", done[0], 1'b0);
    chk1("bad_clr_idok", idok[0], 1'b0);
    chk1("bad_busy", busy[0], 1'b1);
    tick(); tick(); tick(); tick();
    chk1("bad_done", done[0], 1'b1);
    chk1("bad_idok", idok[0], 1'b0);
    chk1("bad_tsok", tsok[0], 1'b1);
    chk32("bad_cid", cid[0], 32'd292);
    slv_id[0] = EXP_ID;
    pulse_start(0);
    chk1("re_clr_tsok", tsok[0], 1'b0);
    chk1("re_clr_done", done[0], 1'b0);
    tick(); tick(); tick(); tick();
    chk1("re_done", done[0], 1'b1);
    chk1("re_idok", idok[0], 1'b1);

    // 7 wait states per read: request held stable, done on edge 19
    wait_n[0] = 7;
    pulse_start(0);
    begin
      int bad;
      logic exp_rd;
      bad = 0;
      for (int k = 1; k <= 19; k++) begin
        if (k > 1) tick();
        exp_rd = (k <= 8) || (k >= 10 && k <= 17);
        if (rd[0] !== exp_rd) bad++;
        if (exp_rd && (addr[0] !== (k >= 10))) bad++;
        if (k < 19 && done[0] !== 1'b0) bad++;
      end
      chk32("wait_stable", 32'(bad), 32'd0);
    end
    chk1("wait_done19", done[0], 1'b1);
    chk1("wait_idok", idok[0], 1'b1);
    chk1("wait_tsok", tsok[0], 1'b1);
    wait_n[0] = 0;

    // reset during a stalled ID request drops avm_read at once
    wait_n[0] = 7;
    pulse_start(0);
    chk1("rreq_read", rd[0], 1'b1);
    #2 rst[0] = 1'b1;
    #1;
    chk1("rreq_async_read", rd[0], 1'b0);
    chk1("rreq_async_busy", busy[0], 1'b0);
    wait_n[0] = 0;
    tick();
    @(negedge clock);
    rst[0] = 1'b0;
    tick(); tick(); tick(); tick(); tick();
    chk1("rreq_recheck_done", done[0], 1'b1);

    // reset while in RD_TS_WAIT, then a fresh automatic check
    pulse_start(0);
    tick(); tick(); tick();
    chk1("rts_busy", busy[0], 1'b1);
    chk1("rts_addr", addr[0], 1'b1);
    #2 rst[0] = 1'b1;
    #1;
    chk1("rts_async_busy", busy[0], 1'b0);
    chk1("rts_async_read", rd[0], 1'b0);
    chk1("rts_async_done", done[0], 1'b0);
    chk32("rts_async_cid", cid[0], 32'd0);
    tick();
    @(negedge clock);
    rst[0] = 1'b0;
    tick(); tick(); tick(); tick();
    chk1("rts_re_done4", done[0], 1'b0);
    tick();
    chk1("rts_re_done5", done[0], 1'b1);
    chk1("rts_re_idok", idok[0], 1'b1);
    chk1("rts_re_tsok", tsok[0], 1'b1);

    // timeout: 10 cycles in the ID transaction with no data
    pulse_start(1);
    for (int k = 0; k < 9; k++) tick();
    chk1("to_done10", done[1], 1'b0);
    chk1("to_busy10", busy[1], 1'b1);
    tick();
    chk1("to_done", done[1], 1'b1);
    chk1("to_flag", tmo[1], 1'b1);
    chk1("to_idok", idok[1], 1'b0);
    chk1("to_tsok", tsok[1], 1'b0);
    chk1("to_busy", busy[1], 1'b0);
    inj_data[1] = EXP_ID;
    inj[1] = 1'b1;
    tick();
    inj[1] = 1'b0;
    tick();
    chk32("to_late_cid", cid[1], 32'd0);
    chk1("to_late_done", done[1], 1'b1);

    // data in the limit cycle wins, then the TS read times out
    pulse_start(1);
    chk1("tw_clr_timeout", tmo[1], 1'b0);
    for (int k = 0; k < 9; k++) tick();
    inj[1] = 1'b1;
    tick();
    inj[1] = 1'b0;
    chk32("tw_cid", cid[1], EXP_ID);
    chk1("tw_read_ts", rd[1], 1'b1);
    chk1("tw_addr_ts", addr[1], 1'b1);
    chk1("tw_not_done", done[1], 1'b0);
    for (int k = 0; k < 9; k++) tick();
    chk1("tw_ts_done19", done[1], 1'b0);
    tick();
    chk1("tw_ts_done", done[1], 1'b1);
    chk1("tw_ts_timeout", tmo[1], 1'b1);
    chk1("tw_ts_idok", idok[1], 1'b0);

    // CHECK_TS = 0: one address-0 read, done on edge 3, start while busy ignored
    pulse_start(2);
    chk1("nots_busy", busy[2], 1'b1);
    start[2] = 1'b1;
    tick();
    start[2] = 1'b0;
    chk1("nots_done2", done[2], 1'b0);
    tick();
    chk1("nots_done3", done[2], 1'b1);
    chk1("nots_idok", idok[2], 1'b1);
    chk1("nots_tsok", tsok[2], 1'b1);
    chk1("nots_timeout", tmo[2], 1'b0);
    tick(); tick();
    chk32("nots_reads", 32'(reads[2]), 32'd1);
    chk1("nots_no_ts_read", ts_seen[2], 1'b0);
    chk1("nots_done_held", done[2], 1'b1);
    chk32("nots_cts", cts[2], 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
